serial_subtractor: RTL

Bit-serial, LSB-first subtractor that reuses a single full-subtractor cell and a borrow flip-flop. It computes diff = a − b − b_in over WIDTH cycles. It is the inverse-operation companion to the combinational full adder, and sits beside it in the arithmetic datapath wherever area matters more than latency. A start/busy/done handshake frames each operation, and a per-bit serial stream is exposed for downstream serial consumers.

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 106 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// master drives the request side; slave is the subtractor itself.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             bit_valid;
  logic             diff_bit;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, bit_valid, diff_bit
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, bit_valid, diff_bit
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - b_in over WIDTH cycles,
// using one full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             b_out_q, b_out_d;

  logic             x, y, d, bw_next;
  logic [WIDTH-1:0] wd_next;

  assign x       = sa_q[0];
  assign y       = sb_q[0];
  assign d       = x ^ y ^ bw_q;
  assign bw_next = (~x & y) | (~(x ^ y) & bw_q);

  // The new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_wd_one
    assign wd_next = d;
  end else begin : g_wd_many
    assign wd_next = {d, wd_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    wd_d    = wd_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    b_out_d = b_out_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StShift;
          sa_d    = bus.a;
          sb_d    = bus.b;
          bw_d    = bus.b_in;
          cnt_d   = '0;
          wd_d    = '0;
        end
      end
      StShift: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        wd_d  = wd_next;
        bw_d  = bw_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          diff_d  = wd_next;
          b_out_d = bw_next;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      wd_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      b_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      wd_q    <= wd_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      b_out_q <= b_out_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.bit_valid = (state_q == StShift);
  assign bus.diff_bit  = (state_q == StShift) ? d : 1'b0;
  assign bus.diff      = diff_q;
  assign bus.b_out     = b_out_q;

endmodule
